uart_tx: RTL and testbench

- Serial output stage directly downstream of debug_print; drives the board TX pin.
- Accepts bytes over a valid/ready handshake into an internal FIFO.
- Serialises each byte as 8N1: one start bit, 8 data bits LSB first, one stop bit.
- The FIFO lets debug_print emit a short burst of characters (e.g. an error line at EOL) without stalling every byte for a full frame time.

---
 rtl/debug_pkg.sv | 21 ++
 rtl/uart_byte_fifo.sv | 72 +++++++
 rtl/uart_tx.sv | 125 ++++++++++++
 tb/tb_uart_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// ============================================================================
// debug_pkg : constants and state encoding shared by the UART stages
// Revision  : 1.0
// ============================================================================
`default_nettype none

package debug_pkg;

   localparam int UART_DATA_BITS       = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 868;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
// ============================================================================
// uart_byte_fifo : single-clock FIFO with push/pop, occupancy, full and empty
// Revision       : 1.0
// ============================================================================
`default_nettype none

module uart_byte_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   // Full/empty come from the count so pointers can wrap freely.
   assign o_full  = (count_q == CNT_W'(DEPTH));
   assign o_empty = (count_q == '0);
   assign push_ok = i_push && !o_full;
   assign pop_ok  = i_pop && !o_empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= i_data;
   end

   assign o_data  = mem_q[rd_ptr_q];
   assign o_count = count_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx  : FIFO-buffered 8N1 serial transmitter
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx
   import debug_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [7:0]                    i_data,
   input  logic                          i_valid,
   output logic                          o_ready,
   output logic                          o_tx,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_count
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W  = $clog2(UART_DATA_BITS);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

   uart_tx_state_t            state_q, state_d;
   logic [BAUD_W-1:0]         baud_q, baud_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      tx_q, tx_d;
   logic                      pop;
   logic                      baud_tc;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [UART_DATA_BITS-1:0] fifo_head;

   uart_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_valid),
      .i_data  (i_data),
      .i_pop   (pop),
      .o_data  (fifo_head),
      .o_count (o_count),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   assign baud_tc = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      if (state_q != IDLE) baud_d = baud_tc ? '0 : baud_q + BAUD_W'(1);
      case (state_q)
         IDLE: if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            tx_d    = 1'b0;
            baud_d  = '0;
            state_d = START;
         end
         START: if (baud_tc) begin
            tx_d    = shift_q[0];
            idx_d   = '0;
            state_d = DATA;
         end
         DATA: if (baud_tc) begin
            if (idx_q == IDX_LAST) begin
               tx_d    = 1'b1;
               state_d = STOP;
            end else begin
               shift_d = shift_q >> 1;
               tx_d    = shift_q[1];
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         STOP: if (baud_tc) begin
            // Chain straight into the next start bit when more bytes wait.
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_head;
               tx_d    = 1'b0;
               state_d = START;
            end else begin
               tx_d    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   assign o_tx    = tx_q;
   assign o_ready = !fifo_full;
   assign o_busy  = (state_q != IDLE) || !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// tb_uart_tx : directed checks of uart_tx at 4 and 1 clocks per bit
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data4, data1;
   logic       valid4, valid1;
   logic       ready4, ready1, tx4, tx1, busy4, busy1;
   logic [4:0] count4, count1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] rx_q[$];
   int         start_q[$];
   int         stop_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_data(data4), .i_valid(valid4),
      .o_ready(ready4), .o_tx(tx4), .o_busy(busy4), .o_count(count4)
   );

   uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(16)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_data(data1), .i_valid(valid1),
      .o_ready(ready1), .o_tx(tx1), .o_busy(busy1), .o_count(count1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push4(input logic [7:0] b);
      data4  = b;
      valid4 = 1'b1;
      @(posedge clk); #1;
      valid4 = 1'b0;
   endtask

   // Expected line level c cycles after a byte is pushed into an idle dut4.
   function automatic logic exp4(input int c, input logic [7:0] b);
      if (c <= 4)  return 1'b0;
      if (c <= 36) return b[(c - 5) / 4];
      return 1'b1;
   endfunction

   // Decoder for dut4: samples the middle of every bit of each frame.
   initial begin : mon4
      logic [7:0] mb;
      forever begin
         @(posedge clk); #2;
         if (tx4 === 1'b0) begin
            start_q.push_back(cyc);
            repeat (2) @(posedge clk); #2;
            for (int i = 0; i < 8; i++) begin
               repeat (4) @(posedge clk); #2;
               mb[i] = tx4;
            end
            repeat (4) @(posedge clk); #2;
            if (tx4 !== 1'b1) stop_err++;
            rx_q.push_back(mb);
         end
      end
   end

   initial begin
      int       low_seen, n, acc_n, w, errs, peak;
      logic     acc;
      logic [7:0] nxt;

      rst = 1'b1; valid4 = 1'b0; valid1 = 1'b0; data4 = 8'h00; data1 = 8'h00;

      // 1. reset state and quiet line
      repeat (2) @(posedge clk); #1;
      check("rst_tx", tx4, 1);
      check("rst_ready", ready4, 1);
      check("rst_busy", busy4, 0);
      check("rst_count", count4, 0);
      check("rst_tx1", tx1, 1);
      rst = 1'b0;
      low_seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (tx4 !== 1'b1) low_seen++;
      end
      check("idle_no_fall", low_seen, 0);
      check("idle_no_frame", start_q.size(), 0);

      // 2. single byte 0x55, cycle-exact waveform
      push4(8'h55);
      check("single_count_n", count4, 1);
      for (int c = 1; c <= 44; c++) begin
         @(posedge clk); #1;
         check($sformatf("single_tx_c%0d", c), tx4, exp4(c, 8'h55));
         if (c == 1)  check("single_count_n1", count4, 0);
         if (c == 40) check("single_busy_n40", busy4, 1);
         if (c == 41) check("single_busy_n41", busy4, 0);
      end
      check("single_decode", rx_q.size() == 1 ? rx_q[0] : 32'hFFFF, 8'h55);
      rx_q.delete(); start_q.delete();

      // 3. burst "AB\n", back-to-back frames
      data4 = 8'h41; valid4 = 1'b1; @(posedge clk); #1;
      peak = count4;
      data4 = 8'h42; @(posedge clk); #1;
      if (count4 > peak) peak = count4;
      data4 = 8'h0A; @(posedge clk); #1;
      valid4 = 1'b0;
      for (int i = 0; i < 140; i++) begin
         if (count4 > peak) peak = count4;
         @(posedge clk); #1;
      end
      check("burst_peak", peak, 2);
      check("burst_nframes", start_q.size(), 3);
      check("burst_rx_size", rx_q.size(), 3);
      if (rx_q.size() == 3) begin
         check("burst_b0", rx_q[0], 8'h41);
         check("burst_b1", rx_q[1], 8'h42);
         check("burst_b2", rx_q[2], 8'h0A);
      end
      if (start_q.size() == 3) begin
         check("burst_gap0", start_q[1] - start_q[0], 40);
         check("burst_gap1", start_q[2] - start_q[1], 40);
      end
      check("burst_stop_err", stop_err, 0);
      check("burst_idle", busy4, 0);
      rx_q.delete(); start_q.delete();

      // 4. backpressure with incrementing bytes
      nxt = 8'h00; acc_n = 0; valid4 = 1'b1;
      for (int k = 0; k < 40 && acc_n < 17; k++) begin
         data4 = nxt; acc = ready4;
         @(posedge clk); #1;
         if (acc) begin acc_n++; nxt++; end
      end
      check("bp_accepted", acc_n, 17);
      check("bp_ready_low", ready4, 0);
      check("bp_count_full", count4, 16);
      w = 0;
      while (ready4 !== 1'b1 && w < 100) begin
         data4 = 8'hEE;
         @(posedge clk); #1;
         w++;
      end
      check("bp_ready_rise_wait", w, 25);
      for (int k = 0; k < 400 && acc_n < 20; k++) begin
         acc = ready4;
         data4 = acc ? nxt : 8'hEE;
         @(posedge clk); #1;
         if (acc) begin acc_n++; nxt++; end
      end
      valid4 = 1'b0;
      check("bp_accepted_total", acc_n, 20);
      repeat (900) @(posedge clk); #1;
      check("bp_rx_size", rx_q.size(), 20);
      errs = 0;
      for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== 8'(i)) errs++;
      check("bp_rx_order", errs, 0);
      errs = 0;
      for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != 40) errs++;
      check("bp_no_gaps", errs, 0);
      check("bp_stop_err", stop_err, 0);
      rx_q.delete(); start_q.delete();

      // 5. reset during data bit 3 with a second byte queued
      push4(8'hA5);
      push4(8'h3C);
      repeat (16) @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_tx", tx4, 1);
      check("midrst_count", count4, 0);
      check("midrst_busy", busy4, 0);
      rst = 1'b0;
      n = start_q.size();
      low_seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (tx4 !== 1'b1) low_seen++;
      end
      check("midrst_quiet", low_seen, 0);
      check("midrst_no_frame", start_q.size(), n);
      rx_q.delete(); start_q.delete();

      // 6. one clock per bit: 0xFF then 0x00, back-to-back 10-cycle frames
      data1 = 8'hFF; valid1 = 1'b1;
      @(posedge clk); #1;
      data1 = 8'h00;
      @(posedge clk); #1;
      valid1 = 1'b0;
      check("cpb1_count", count1, 1);
      for (int c = 1; c <= 21; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         check($sformatf("cpb1_tx_c%0d", c), tx1,
               (c == 1 || (c >= 11 && c <= 19)) ? 1'b0 : 1'b1);
         if (c == 20) check("cpb1_busy_c20", busy1, 1);
         if (c == 21) check("cpb1_busy_c21", busy1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
